// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, addresses the
// instruction ROM (combinational read) and registers the returned word
// into the IF/ID pipeline register. Handles stall, branch/jump redirect
// with flush, HALT detection and a saturating count of issued words.
module fetch_stage #(
    parameter logic [15:0] START_PC = 16'd1,
    parameter logic [4:0]  HALT_OP  = 5'b11010,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [15:0]      redirect_pc,
    input  logic [8:0]       rom_instr,
    output logic [15:0]      pc,
    output logic [8:0]       if_id_instr,
    output logic [15:0]      if_id_pc,
    output logic             if_id_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_HALTED = 1'b1;

    logic             state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [8:0]       instr_q, instr_d;
    logic [15:0]      ipc_q, ipc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_halt;

    // Only the opcode field is inspected; operand bits pass through untouched.
    assign is_halt = (rom_instr[8:4] == HALT_OP);

    // Next-state selection: redirect beats stall, stall beats a normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (redirect) begin
            // Flush whatever was fetched down the wrong path, even if stalled.
            pc_d    = redirect_pc;
            instr_d = '0;
            ipc_d   = '0;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (!stall) begin
                instr_d = rom_instr;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (is_halt) begin
                    // Park on the HALT address; a later redirect can still resume.
                    state_d = ST_HALTED;
                end else begin
                    pc_d = pc_q + 16'd1;
                end
            end
        end else begin
            // Halted: issue the HALT once, but keep it while decode is stalled.
            if (!stall) begin
                instr_d = '0;
                ipc_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    // State registers with immediate (asynchronous) reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= START_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, hand-written corner sequences and
// randomized traffic checked against a behavioural reference model.
module tb_fetch_stage;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [15:0]   redirect_pc = 16'd0;
    logic [8:0]    rom_instr;
    logic [15:0]   pc;
    logic [8:0]    if_id_instr;
    logic [15:0]   if_id_pc;
    logic          if_id_valid;
    logic          halted;
    logic [CW-1:0] fetch_count;

    logic [8:0] rom [0:65535];

    int total = 0;
    int bad = 0;

    // Behavioural model of the fetch stage
    logic [15:0]   m_pc;
    logic          m_h;
    logic          m_v;
    logic [8:0]    m_i;
    logic [15:0]   m_ip;
    int            m_cnt;

    typedef struct {
        logic        st;
        logic        rd;
        logic [15:0] rpc;
        logic [15:0] epc;
        logic        ev;
        logic [8:0]  ei;
        logic [15:0] eip;
        logic        eh;
        int          ec;
    } vec_t;

    vec_t tbl [7];

    fetch_stage #(.START_PC(16'd1), .HALT_OP(5'b11010), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .rom_instr(rom_instr), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign rom_instr = rom[pc];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_all(input string tag, input logic [15:0] epc, input logic ev,
                              input logic [8:0] ei, input logic [15:0] eip,
                              input logic eh, input int ec);
        chk({tag, ".pc"}, 32'(pc), 32'(epc));
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(ev));
        chk({tag, ".instr"}, 32'(if_id_instr), 32'(ei));
        chk({tag, ".ifpc"}, 32'(if_id_pc), 32'(eip));
        chk({tag, ".halted"}, 32'(halted), 32'(eh));
        chk({tag, ".count"}, 32'(fetch_count), 32'(ec));
    endtask

    task automatic model_reset();
        m_pc = 16'd1; m_h = 1'b0; m_v = 1'b0; m_i = 9'd0; m_ip = 16'd0; m_cnt = 0;
    endtask

    // One clock of the spec's rules: redirect first, then stall, then fetch.
    task automatic model_step(input logic st, input logic rd, input logic [15:0] rpc);
        logic [8:0] w;
        if (rd) begin
            m_pc = rpc; m_h = 1'b0; m_v = 1'b0; m_i = 9'd0; m_ip = 16'd0;
        end else if (!st) begin
            if (m_h) begin
                m_v = 1'b0; m_i = 9'd0; m_ip = 16'd0;
            end else begin
                w = rom[m_pc];
                m_i = w; m_ip = m_pc; m_v = 1'b1;
                if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
                if (w[8:4] == 5'b11010) m_h = 1'b1;
                else m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
        stall = st; redirect = rd; redirect_pc = rpc;
        model_step(st, rd, rpc);
        @(posedge clk);
        #1;
        expect_all("model", m_pc, m_v, m_i, m_ip, m_h, m_cnt);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = {1'b0, 8'(a)};
        rom[1]  = 9'h0C0;
        rom[2]  = 9'h120;
        rom[3]  = 9'h190;
        rom[39] = 9'h1A0;
        rom[50] = 9'h1A5;

        tbl[0] = '{1'b0, 1'b0, 16'd0, 16'd2, 1'b1, 9'h0C0, 16'd1, 1'b0, 1};
        tbl[1] = '{1'b0, 1'b0, 16'd0, 16'd3, 1'b1, 9'h120, 16'd2, 1'b0, 2};
        tbl[2] = '{1'b0, 1'b0, 16'd0, 16'd4, 1'b1, 9'h190, 16'd3, 1'b0, 3};
        tbl[3] = '{1'b0, 1'b0, 16'd0, 16'd5, 1'b1, 9'h004, 16'd4, 1'b0, 4};
        tbl[4] = '{1'b1, 1'b0, 16'd0, 16'd5, 1'b1, 9'h004, 16'd4, 1'b0, 4};
        tbl[5] = '{1'b1, 1'b0, 16'd0, 16'd5, 1'b1, 9'h004, 16'd4, 1'b0, 4};
        tbl[6] = '{1'b0, 1'b0, 16'd0, 16'd6, 1'b1, 9'h005, 16'd5, 1'b0, 5};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_all("reset", 16'd1, 1'b0, 9'd0, 16'd0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: clean fetches and a two-cycle stall
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].st, tbl[k].rd, tbl[k].rpc);
            expect_all($sformatf("tbl%0d", k), tbl[k].epc, tbl[k].ev, tbl[k].ei,
                       tbl[k].eip, tbl[k].eh, tbl[k].ec);
        end

        // Advance to pc=14, then redirect together with stall
        repeat (8) step(1'b0, 1'b0, 16'd0);
        expect_all("at14", 16'd14, 1'b1, 9'h00D, 16'd13, 1'b0, 13);
        step(1'b1, 1'b1, 16'd26);
        expect_all("redir_stall", 16'd26, 1'b0, 9'd0, 16'd0, 1'b0, 13);
        step(1'b0, 1'b0, 16'd0);
        expect_all("redir_tgt", 16'd27, 1'b1, 9'h01A, 16'd26, 1'b0, 14);

        // HALT at 39: issued once, held under stall, then bubbles
        step(1'b0, 1'b1, 16'd39);
        expect_all("to39", 16'd39, 1'b0, 9'd0, 16'd0, 1'b0, 14);
        step(1'b0, 1'b0, 16'd0);
        expect_all("halt", 16'd39, 1'b1, 9'h1A0, 16'd39, 1'b1, 15);
        step(1'b1, 1'b0, 16'd0);
        expect_all("halt_stall", 16'd39, 1'b1, 9'h1A0, 16'd39, 1'b1, 15);
        for (int k = 0; k < 11; k++) begin
            step(1'b0, 1'b0, 16'd0);
            expect_all($sformatf("halted%0d", k), 16'd39, 1'b0, 9'd0, 16'd0, 1'b1, 15);
        end

        // Resume from HALTED via redirect
        step(1'b0, 1'b1, 16'd13);
        expect_all("resume", 16'd13, 1'b0, 9'd0, 16'd0, 1'b0, 15);
        step(1'b0, 1'b0, 16'd0);
        expect_all("resume_f", 16'd14, 1'b1, 9'h00D, 16'd13, 1'b0, 16);

        // PC wrap
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 16'd0);
        expect_all("wrap", 16'h0000, 1'b1, 9'h0FF, 16'hFFFF, 1'b0, 17);
        step(1'b0, 1'b0, 16'd0);
        expect_all("wrap2", 16'h0001, 1'b1, 9'h000, 16'h0000, 1'b0, 18);

        // Asynchronous reset between edges
        stall = 1'b0; redirect = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        expect_all("async_rst", 16'd1, 1'b0, 9'd0, 16'd0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter saturation: 38 plain words plus HALT exceed 31
        repeat (40) step(1'b0, 1'b0, 16'd0);
        expect_all("sat", 16'd39, 1'b0, 9'd0, 16'd0, 1'b1, 31);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic st, rd;
            logic [15:0] rpc;
            st = ($urandom_range(0, 99) < 25);
            rd = ($urandom_range(0, 99) < 12);
            rpc = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom_range(0, 63));
            step(st, rd, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
